// File: rtl/vector_div_scheduler.sv
// vector_div_scheduler
//   Runs one vector-by-scalar division job through a single shared, pipelined
//   integer divider. The block latches a numerator vector and an unsigned
//   divisor. It then issues one element per cycle to the divider. Quotients
//   may come back in any order; they are collected by tag, and the full
//   quotient vector is presented downstream.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   vld_in/rdy_out job handshake; vec_in (packed, element 0 in the LSBs), divisor_in
//   vld_out/rdy_in result handshake; vec_out (registered, packed like vec_in)
//   div_vld_out/div_rdy_in   divider request: div_num_out, div_den_out, div_idx_out
//   div_vld_in               divider response: div_quot_in, div_idx_in (no backpressure)
//   busy           high while a job is being issued or is waiting to be taken
module vector_div_scheduler #(
    parameter int VEC_LEN    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = $clog2(VEC_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_out,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] vec_in,
    input  logic [DATA_WIDTH-1:0]         divisor_in,
    output logic                          vld_out,
    input  logic                          rdy_in,
    output logic [VEC_LEN*DATA_WIDTH-1:0] vec_out,
    output logic                          div_vld_out,
    input  logic                          div_rdy_in,
    output logic [DATA_WIDTH-1:0]         div_num_out,
    output logic [DATA_WIDTH-1:0]         div_den_out,
    output logic [IDX_WIDTH-1:0]          div_idx_out,
    input  logic                          div_vld_in,
    input  logic [DATA_WIDTH-1:0]         div_quot_in,
    input  logic [IDX_WIDTH-1:0]          div_idx_in,
    output logic                          busy
);

    // Counters need one extra bit so they can hold VEC_LEN itself.
    localparam int CNT_W = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(VEC_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  vec_q  [VEC_LEN];
    logic [DATA_WIDTH-1:0]  den_q;
    logic [DATA_WIDTH-1:0]  quot_q [VEC_LEN];
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       resp_cnt_q, resp_cnt_d;
    logic                   rdy_out_q;
    logic                   vld_out_q;

    logic                   issue_vld;
    logic [IDX_WIDTH-1:0]   issue_idx;
    logic                   resp_in_range;

    assign issue_vld = (state_q == ISSUE) && (issue_cnt_q < LEN_C);
    assign issue_idx = issue_cnt_q[IDX_WIDTH-1:0];

    // Request fields are forced to zero whenever no request is offered.
    assign div_vld_out = issue_vld;
    assign div_num_out = issue_vld ? vec_q[issue_idx] : '0;
    assign div_den_out = issue_vld ? den_q : '0;
    assign div_idx_out = issue_vld ? issue_idx : '0;

    // Out-of-range tags still count as a response but never write.
    assign resp_in_range = ({1'b0, div_idx_in} < LEN_C);

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        if (issue_vld && div_rdy_in) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        // Saturate so that surplus responses can never wrap the count.
        if (div_vld_in && (resp_cnt_q != LEN_C)) begin
            resp_cnt_d = resp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            rdy_out_q   <= 1'b1;
            vld_out_q   <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                quot_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_in) begin
                        for (int i = 0; i < VEC_LEN; i++) begin
                            vec_q[i] <= vec_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        den_q       <= divisor_in;
                        issue_cnt_q <= '0;
                        resp_cnt_q  <= '0;
                        rdy_out_q   <= 1'b0;
                        if (divisor_in != '0) begin
                            state_q <= ISSUE;
                        end else begin
                            // Divide by zero: all-ones result, divider never used.
                            state_q <= DONE;
                            for (int i = 0; i < VEC_LEN; i++) begin
                                quot_q[i] <= '1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    issue_cnt_q <= issue_cnt_d;
                    resp_cnt_q  <= resp_cnt_d;
                    if (div_vld_in && resp_in_range) begin
                        quot_q[div_idx_in] <= div_quot_in;
                    end
                    if (resp_cnt_q == LEN_C) begin
                        state_q   <= DONE;
                        vld_out_q <= 1'b1;
                    end
                end
                DONE: begin
                    // vld_out rises one cycle after entry on the divide-by-zero path.
                    if (vld_out_q && rdy_in) begin
                        state_q   <= IDLE;
                        vld_out_q <= 1'b0;
                        rdy_out_q <= 1'b1;
                    end else begin
                        vld_out_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < VEC_LEN; g++) begin : g_vec_out
        assign vec_out[g*DATA_WIDTH +: DATA_WIDTH] = quot_q[g];
    end

    assign rdy_out = rdy_out_q;
    assign vld_out = vld_out_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vector_div_scheduler.sv
// Directed bench for vector_div_scheduler with a behavioural latency-1 divider.
module tb_vector_div_scheduler;

    localparam int VL = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              vld_in;
    logic              rdy_out;
    logic [VL*DW-1:0]  vec_in;
    logic [DW-1:0]     divisor_in;
    logic              vld_out;
    logic              rdy_in;
    logic [VL*DW-1:0]  vec_out;
    logic              div_vld_out;
    logic              div_rdy_in;
    logic [DW-1:0]     div_num_out;
    logic [DW-1:0]     div_den_out;
    logic [IW-1:0]     div_idx_out;
    logic              div_vld_in;
    logic [DW-1:0]     div_quot_in;
    logic [IW-1:0]     div_idx_in;
    logic              busy;

    vector_div_scheduler #(.VEC_LEN(VL), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .vld_in(vld_in), .rdy_out(rdy_out), .vec_in(vec_in), .divisor_in(divisor_in),
        .vld_out(vld_out), .rdy_in(rdy_in), .vec_out(vec_out),
        .div_vld_out(div_vld_out), .div_rdy_in(div_rdy_in),
        .div_num_out(div_num_out), .div_den_out(div_den_out), .div_idx_out(div_idx_out),
        .div_vld_in(div_vld_in), .div_quot_in(div_quot_in), .div_idx_in(div_idx_in),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int vld_lat = -1;
    int first_req = -1;
    int last_req  = -1;
    int pulses    = 0;
    bit vld_seen  = 1'b0;
    bit auto_resp = 1'b1;
    logic [DW-1:0] req_idx[$];
    logic [DW-1:0] req_num[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, let the edge happen, drive at edge+1.
    task automatic tick();
        bit            hs;
        logic [DW-1:0] q;
        logic [IW-1:0] ix;
        q  = '0;
        ix = '0;
        @(negedge clk);
        hs = div_vld_out && div_rdy_in;
        if (div_vld_out) pulses++;
        if (hs) begin
            req_idx.push_back(DW'(div_idx_out));
            req_num.push_back(div_num_out);
            if (first_req < 0) first_req = cyc + 1 - acc_cyc;
            last_req = cyc + 1 - acc_cyc;
            q  = (div_den_out != '0) ? div_num_out / div_den_out : '1;
            ix = div_idx_out;
        end
        if (vld_out && !vld_seen) begin
            vld_seen = 1'b1;
            vld_lat  = cyc - acc_cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (auto_resp) begin
            div_vld_in  = hs;
            div_quot_in = q;
            div_idx_in  = ix;
        end
    endtask

    task automatic accept(input logic [VL*DW-1:0] v, input logic [DW-1:0] d);
        vec_in     = v;
        divisor_in = d;
        vld_in     = 1'b1;
        vld_seen   = 1'b0;
        vld_lat    = -1;
        first_req  = -1;
        last_req   = -1;
        pulses     = 0;
        req_idx.delete();
        req_num.delete();
        tick();
        acc_cyc = cyc;
        vld_in  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        for (int k = 0; k < 40 && !vld_seen; k++) begin
            if (toggle) div_rdy_in = (k % 2 == 0);
            tick();
        end
        div_rdy_in = 1'b1;
        chk({tag, "_timeout"}, vld_seen, 1);
    endtask

    task automatic release_out();
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0; vec_in = '0; divisor_in = '0; rdy_in = 1'b0;
        div_rdy_in = 1'b1; div_vld_in = 1'b0; div_quot_in = '0; div_idx_in = '0;
        repeat (3) tick();
        chk("rst_rdy_out", rdy_out, 1);
        chk("rst_vld_out", vld_out, 0);
        chk("rst_div_vld", div_vld_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vec_out", vec_out, 0);
        chk("rst_div_num", {div_num_out, div_den_out, 14'd0, div_idx_out}, 0);
        rst = 1'b0;
        tick();

        // Test 1: [9,12,7,0]/3, in-order responses, always ready.
        accept({16'd0, 16'd7, 16'd12, 16'd9}, 16'd3);
        chk("t1_busy", busy, 1);
        chk("t1_rdy_out_low", rdy_out, 0);
        wait_done("t1", 1'b0);
        chk("t1_lat", vld_lat, 6);
        chk("t1_first_req", first_req, 1);
        chk("t1_last_req", last_req, 4);
        chk("t1_nreq", req_idx.size(), 4);
        if (req_idx.size() == 4) begin
            chk("t1_order", {req_idx[0], req_idx[1], req_idx[2], req_idx[3]}, {16'd0, 16'd1, 16'd2, 16'd3});
            chk("t1_nums", {req_num[0], req_num[1], req_num[2], req_num[3]}, {16'd9, 16'd12, 16'd7, 16'd0});
        end
        chk("t1_vec_out", vec_out, {16'd0, 16'd2, 16'd4, 16'd3});
        release_out();
        chk("t1_idle_rdy", rdy_out, 1);

        // A response while idle must not write.
        auto_resp = 1'b0;
        div_vld_in = 1'b1; div_idx_in = 2'd0; div_quot_in = 16'h0077;
        tick();
        div_vld_in = 1'b0;
        tick();
        auto_resp = 1'b1;
        chk("idle_resp_ignored", vec_out, {16'd0, 16'd2, 16'd4, 16'd3});

        // Test 2: same job, divider ready toggling 1,0,1,0.
        accept({16'd0, 16'd7, 16'd12, 16'd9}, 16'd3);
        wait_done("t2", 1'b1);
        chk("t2_nreq", req_idx.size(), 4);
        if (req_idx.size() == 4)
            chk("t2_order", {req_idx[0], req_idx[1], req_idx[2], req_idx[3]}, {16'd0, 16'd1, 16'd2, 16'd3});
        chk("t2_vec_out", vec_out, {16'd0, 16'd2, 16'd4, 16'd3});
        release_out();

        // Test 3: responses returned as idx 3,1,0,2.
        auto_resp = 1'b0;
        div_vld_in = 1'b0;
        accept({16'd0, 16'd7, 16'd12, 16'd9}, 16'd3);
        repeat (5) tick();
        chk("t3_nreq", req_idx.size(), 4);
        div_vld_in = 1'b1;
        div_idx_in = 2'd3; div_quot_in = 16'd0; tick();
        div_idx_in = 2'd1; div_quot_in = 16'd4; tick();
        div_idx_in = 2'd0; div_quot_in = 16'd3; tick();
        div_vld_in = 1'b0;
        repeat (2) tick();
        chk("t3_no_early_vld", vld_out, 0);
        div_vld_in = 1'b1;
        div_idx_in = 2'd2; div_quot_in = 16'd2; tick();
        div_vld_in = 1'b0;
        chk("t3_vld_after_4th", vld_out, 0);
        wait_done("t3", 1'b0);
        chk("t3_vec_out", vec_out, {16'd0, 16'd2, 16'd4, 16'd3});
        release_out();
        auto_resp = 1'b1;

        // Test 4: divide by zero.
        accept({16'd5, 16'd6, 16'd7, 16'd8}, 16'd0);
        wait_done("t4", 1'b0);
        chk("t4_lat", vld_lat, 1);
        chk("t4_pulses", pulses, 0);
        chk("t4_vec_out", vec_out, {64{1'b1}});

        // Test 5: downstream stalls for 5 cycles in DONE.
        repeat (5) tick();
        chk("t5_vld_hold", vld_out, 1);
        chk("t5_vec_hold", vec_out, {64{1'b1}});
        chk("t5_rdy_out_low", rdy_out, 0);
        release_out();
        chk("t5_rdy_out_rise", rdy_out, 1);
        chk("t5_vld_drop", vld_out, 0);
        chk("t5_busy_drop", busy, 0);

        // Test 6: reset after two requests, then a fresh job.
        accept({16'd0, 16'd7, 16'd12, 16'd9}, 16'd3);
        repeat (2) tick();
        chk("t6_two_issued", req_idx.size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        div_vld_in = 1'b0;
        chk("t6_rdy_out", rdy_out, 1);
        chk("t6_busy", busy, 0);
        chk("t6_div_vld", div_vld_out, 0);
        accept({16'd1, 16'd25, 16'd50, 16'd100}, 16'd5);
        wait_done("t6", 1'b0);
        chk("t6_vec_out", vec_out, {16'd0, 16'd5, 16'd10, 16'd20});
        chk("t6_lat", vld_lat, 6);
        release_out();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
